// File: rtl/tpu_pkg.sv
// Shared definitions for the MMU sequencer slice.
//   seq_state_t   : sequencer FSM states
//   W_WAIT_CYC    : W_WAIT dwell for the default tile edge (SIZE+4)
//   w_wait_cycles : same dwell for an arbitrary tile edge
package tpu_pkg;

  typedef enum logic [3:0] {
    IDLE, W_RD, W_PUSH, W_LD, W_WAIT, SWAP,
    D_RD, D_PUSH, D_RUN, R_POP, R_WR, DONE
  } seq_state_t;

  localparam int unsigned SEQ_SIZE_DFLT = 2;
  localparam int unsigned W_WAIT_CYC    = SEQ_SIZE_DFLT + 4;

  // Weights need SIZE+4 cycles to settle in the array after the load handshake.
  function automatic int unsigned w_wait_cycles(input int unsigned size);
    return size + 4;
  endfunction

endpackage

// File: rtl/mmu_sequencer_if.sv
// Bus bundle between the MMU sequencer and its environment.
// Groups: command (cmd_*), tile memory read (rd_*), result write (wr_*),
// weight push, data push, result pop, MMU control, and status (busy/done).
// modport master : sequencer side
// modport slave  : environment side (memory, MMU, command source)
interface mmu_sequencer_if #(
  parameter int SIZE   = 2,
  parameter int ADDR_W = 8
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [ADDR_W-1:0]               cmd_w_addr;
  logic [ADDR_W-1:0]               cmd_d_addr;
  logic [ADDR_W-1:0]               cmd_r_addr;
  logic [7:0]                      cmd_n_tiles;

  logic                            rd_en;
  logic [ADDR_W-1:0]               rd_addr;
  logic [SIZE-1:0][SIZE-1:0][7:0]  rd_data;

  logic                            wr_en;
  logic [ADDR_W-1:0]               wr_addr;
  logic [SIZE-1:0][SIZE-1:0][31:0] wr_data;

  logic [SIZE-1:0][SIZE-1:0][7:0]  new_weight_out;
  logic                            new_weight_rdy;
  logic                            new_weight_push;

  logic [SIZE-1:0][SIZE-1:0][7:0]  data_out;
  logic                            data_rdy;
  logic                            data_push;

  logic [SIZE-1:0][SIZE-1:0][31:0] acc_in;
  logic                            acc_in_rdy;
  logic                            acc_in_pop;

  logic                            weight_ld_rdy;
  logic                            weight_ld_start;
  logic                            weight_swap;
  logic                            mult_rdy;
  logic                            mult_run;

  logic                            busy;
  logic                            done;

  modport master (
    input  cmd_valid, cmd_w_addr, cmd_d_addr, cmd_r_addr, cmd_n_tiles,
           rd_data, new_weight_rdy, data_rdy, acc_in, acc_in_rdy,
           weight_ld_rdy, mult_rdy,
    output cmd_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           new_weight_out, new_weight_push, data_out, data_push, acc_in_pop,
           weight_ld_start, weight_swap, mult_run, busy, done
  );

  modport slave (
    output cmd_valid, cmd_w_addr, cmd_d_addr, cmd_r_addr, cmd_n_tiles,
           rd_data, new_weight_rdy, data_rdy, acc_in, acc_in_rdy,
           weight_ld_rdy, mult_rdy,
    input  cmd_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           new_weight_out, new_weight_push, data_out, data_push, acc_in_pop,
           weight_ld_start, weight_swap, mult_run, busy, done
  );
endinterface

// File: rtl/mmu_sequencer_relu.sv
// seq_relu: combinational per-element clamp of a SIZE x SIZE result tile.
// Optional feature macro: MMU_SEQ_RELU_EN. When defined, negative signed
// 32-bit elements become 0; otherwise the tile passes through unchanged.
// Ports: i_res (tile in), o_res (tile out).
module seq_relu #(
  parameter int SIZE = 2
) (
  input  logic [SIZE-1:0][SIZE-1:0][31:0] i_res,
  output logic [SIZE-1:0][SIZE-1:0][31:0] o_res
);

`ifdef MMU_SEQ_RELU_EN
  function automatic logic [31:0] relu_clamp(input logic signed [31:0] v);
    return (v < 0) ? 32'd0 : v;
  endfunction
`endif

  always_comb begin
    o_res = '0;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
`ifdef MMU_SEQ_RELU_EN
        o_res[r][c] = relu_clamp(i_res[r][c]);
`else
        o_res[r][c] = i_res[r][c];
`endif
      end
    end
  end

endmodule

// File: rtl/mmu_sequencer.sv
// mmu_sequencer: runs one matrix-unit command: load a weight tile, then for
// each of n_tiles data tiles read/push/run/pop/write the result tile.
// Ports: clk, rst_n (async, active-low), bus (mmu_sequencer_if.master).
// Optional feature macro: MMU_SEQ_RELU_EN (ReLU clamp on written results,
// handled in seq_relu; latency is the same either way).
module mmu_sequencer
  import tpu_pkg::*;
#(
  parameter int SIZE   = 2,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mmu_sequencer_if.master        bus
);

  localparam logic [7:0] WAIT_LAST = 8'(w_wait_cycles(SIZE) - 1);

  seq_state_t                      r_state;
  seq_state_t                      w_nxt;
  logic [ADDR_W-1:0]               r_w_addr;
  logic [ADDR_W-1:0]               r_d_addr;
  logic [ADDR_W-1:0]               r_r_addr;
  logic [7:0]                      r_n;
  logic [7:0]                      r_i;
  logic [7:0]                      r_cnt;
  logic [SIZE-1:0][SIZE-1:0][7:0]  r_tile;
  logic [SIZE-1:0][SIZE-1:0][31:0] r_res;
  logic [SIZE-1:0][SIZE-1:0][31:0] w_res_out;
  logic                            w_last_tile;

  // 9-bit compare so that n_tiles = 255 terminates after index 254.
  assign w_last_tile = ({1'b0, r_i} + 9'd1) >= {1'b0, r_n};

  seq_relu #(.SIZE(SIZE)) u_relu (
    .i_res (r_res),
    .o_res (w_res_out)
  );

  assign bus.new_weight_out = r_tile;
  assign bus.data_out       = r_tile;
  assign bus.wr_data        = w_res_out;
  assign bus.busy           = (r_state != IDLE);

  // In W_RD/D_RD r_cnt is a phase bit: 0 = issue read, 1 = capture rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_w_addr <= '0;
      r_d_addr <= '0;
      r_r_addr <= '0;
      r_n      <= '0;
      r_i      <= '0;
      r_cnt    <= '0;
      r_tile   <= '0;
      r_res    <= '0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        IDLE: if (bus.cmd_valid) begin
          r_w_addr <= bus.cmd_w_addr;
          r_d_addr <= bus.cmd_d_addr;
          r_r_addr <= bus.cmd_r_addr;
          r_n      <= bus.cmd_n_tiles;
          r_i      <= '0;
          r_cnt    <= '0;
        end
        W_RD, D_RD: begin
          r_cnt <= (r_cnt == 8'd0) ? 8'd1 : 8'd0;
          if (r_cnt != 8'd0) r_tile <= bus.rd_data;
        end
        W_WAIT: r_cnt <= (r_cnt == WAIT_LAST) ? 8'd0 : r_cnt + 8'd1;
        SWAP:   r_i   <= '0;
        R_POP:  if (bus.acc_in_rdy) r_res <= bus.acc_in;
        R_WR:   r_i   <= r_i + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nxt               = r_state;
    bus.cmd_ready       = 1'b0;
    bus.rd_en           = 1'b0;
    bus.rd_addr         = '0;
    bus.wr_en           = 1'b0;
    bus.wr_addr         = '0;
    bus.new_weight_push = 1'b0;
    bus.data_push       = 1'b0;
    bus.acc_in_pop      = 1'b0;
    bus.weight_ld_start = 1'b0;
    bus.weight_swap     = 1'b0;
    bus.mult_run        = 1'b0;
    bus.done            = 1'b0;
    case (r_state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) w_nxt = W_RD;
      end
      W_RD: begin
        if (r_cnt == 8'd0) begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = r_w_addr;
        end else begin
          w_nxt = W_PUSH;
        end
      end
      W_PUSH: begin
        bus.new_weight_push = 1'b1;
        if (bus.new_weight_rdy) w_nxt = W_LD;
      end
      W_LD: begin
        bus.weight_ld_start = 1'b1;
        if (bus.weight_ld_rdy) w_nxt = W_WAIT;
      end
      W_WAIT: if (r_cnt == WAIT_LAST) w_nxt = SWAP;
      SWAP: begin
        bus.weight_swap = 1'b1;
        w_nxt = (r_n == 8'd0) ? DONE : D_RD;
      end
      D_RD: begin
        if (r_cnt == 8'd0) begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = r_d_addr + ADDR_W'(r_i);
        end else begin
          w_nxt = D_PUSH;
        end
      end
      D_PUSH: begin
        bus.data_push = 1'b1;
        if (bus.data_rdy) w_nxt = D_RUN;
      end
      D_RUN: begin
        bus.mult_run = 1'b1;
        if (bus.mult_rdy) w_nxt = R_POP;
      end
      R_POP: if (bus.acc_in_rdy) begin
        bus.acc_in_pop = 1'b1;
        w_nxt = R_WR;
      end
      R_WR: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = r_r_addr + ADDR_W'(r_i);
        w_nxt = w_last_tile ? DONE : D_RD;
      end
      DONE: begin
        bus.done = 1'b1;
        w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/mmu_sequencer.md
MMU_SEQUENCER -- requirements
Module: mmu_sequencer

Interface
REQ-001 SHALL have parameters SIZE (default 2, tile edge) and ADDR_W (default 8, tile-address width).
REQ-002 SHALL have ports clk input 1 (clock) and rst_n input 1 (reset, asynchronous, active-low).
REQ-003 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_w_addr/cmd_d_addr/cmd_r_addr in ADDR_W each, and cmd_n_tiles in 8: one command = weight tile addr, first data tile addr, first result addr, data tile count.
REQ-004 SHALL have rd_en out 1, rd_addr out ADDR_W, and rd_data in 8b[SIZE][SIZE]: tile memory read, data valid exactly 1 cycle after rd_en.
REQ-005 SHALL have wr_en out 1, wr_addr out ADDR_W, and wr_data out 32b[SIZE][SIZE]: result tile write.
REQ-006 SHALL have the weight push group: new_weight_out out 8b[SIZE][SIZE], new_weight_rdy in, new_weight_push out.
REQ-007 SHALL have the data push group: data_out out 8b[SIZE][SIZE], data_rdy in, data_push out.
REQ-008 SHALL have the result pop group: acc_in in 32b[SIZE][SIZE], acc_in_rdy in, acc_in_pop out.
REQ-009 SHALL have the MMU control group: weight_ld_rdy in, weight_ld_start out, weight_swap out, mult_rdy in, mult_run out.
REQ-010 SHALL have busy out 1 (state != IDLE) and done out 1 (one-cycle pulse at command completion).

Function
REQ-011 SHALL be cmd_ready = (state == IDLE); a command transfers on cmd_valid && cmd_ready, and all cmd_* fields are latched into internal registers.
REQ-012 SHALL have states IDLE, W_RD, W_PUSH, W_LD, W_WAIT, SWAP, D_RD, D_PUSH, D_RUN, R_POP, R_WR, DONE.
REQ-013 SHALL, in W_RD, pulse rd_en one cycle with rd_addr = w_addr; the next cycle SHALL capture rd_data into the tile register and enter W_PUSH.
REQ-014 SHALL, in W_PUSH, drive new_weight_out from the tile register and hold new_weight_push high until new_weight_rdy is sampled high, transferring on push && rdy, then go to W_LD.
REQ-015 SHALL, in W_LD, hold weight_ld_start high until weight_ld_rdy is high, then go to W_WAIT.
REQ-016 SHALL stay in W_WAIT exactly SIZE+4 cycles (counter), then enter SWAP.
REQ-017 SHALL assert weight_swap for exactly one cycle in SWAP; the next state SHALL be DONE if n_tiles == 0, else D_RD with tile index i = 0.
REQ-018 SHALL, in D_RD, read rd_addr = d_addr + i, with the capture/latency rule of REQ-013; then D_PUSH.
REQ-019 SHALL, in D_PUSH, drive data_out and assert data_push until data_rdy, then go to D_RUN.
REQ-020 SHALL, in D_RUN, hold mult_run high until mult_rdy, then go to R_POP.
REQ-021 SHALL, in R_POP, wait for acc_in_rdy, then assert acc_in_pop for exactly one cycle while capturing acc_in into the result register, then go to R_WR.
REQ-022 SHALL, in R_WR, pulse wr_en one cycle with wr_addr = r_addr + i and wr_data = the result register (after REQ-031 processing).
REQ-023 SHALL, after R_WR, increment i, going to D_RD if i < n_tiles, else DONE.
REQ-024 SHALL pulse done one cycle in DONE, then go to IDLE.
REQ-025 SHALL compute addresses modulo 2^ADDR_W (wrap, no error).
REQ-026 SHALL use an 8-bit tile index i, so n_tiles = 255 is supported.
REQ-027 SHALL assert at most one of new_weight_push, data_push, acc_in_pop, rd_en, wr_en in any cycle.
REQ-028 SHALL ignore cmd_valid while busy (no queuing).

Reset
REQ-029 SHALL, on rst_n low (any time, including mid-command), force state = IDLE, all strobes/push/pop/start/swap/run/done = 0, busy = 0, counters = 0, and tile/result registers = 0.
REQ-030 SHALL NOT resume an aborted command after reset release.

Configuration
REQ-031 SHALL, when macro MMU_SEQ_RELU_EN is defined, clamp each signed 32-bit result element < 0 to 0 before writing; without it, results SHALL be written unmodified. Latency SHALL be identical either way.

Structure
REQ-032 SHALL place the state enum (seq_state_t) and the W_WAIT constant (SIZE+4) in shared package tpu_pkg.
REQ-033 SHALL contain one sub-module, seq_relu (combinational per-element clamp, bypassed when the macro is absent).

Verification (SIZE=2)
REQ-034 SHALL verify: weights [[1,2],[3,4]] at 0x10, data [[5,6],[7,8]] at 0x20, n=1, r=0x40, with an MMU model -> exactly one wr_en, wr_addr 0x40, wr_data = MMU model output, done pulsed once.
REQ-035 SHALL verify: n_tiles = 0 -> weight push, ld_start, swap each once; no data_push, no wr_en; done 1 cycle after swap.
REQ-036 SHALL verify: new_weight_rdy/data_rdy/acc_in_rdy held low 5 cycles -> push/pop held stable, no extra transfers; each completes once rdy rises.
REQ-037 SHALL verify: n = 3, d = 0xFE, r = 0xFF -> reads 0xFE, 0xFF, 0x00; writes 0xFF, 0x00, 0x01.
REQ-038 SHALL verify: rst_n asserted during D_RUN -> all outputs 0 within the same cycle (async), cmd_ready = 1 after release, no write.
REQ-039 SHALL verify: with MMU_SEQ_RELU_EN, acc_in [[-5,7],[0,-1]] -> wr_data [[0,7],[0,0]]; without the macro, the value is written unchanged.
